// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-port SRAM command/response controller; optional range check via SRAM_CTRL_ADDR_CHK_EN
module sram_ctrl #(
    parameter int DP = 512,
    parameter int DW = 32,
    parameter int MW = 4,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_read,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [MW-1:0] cmd_wmask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [DW-1:0] ram_din,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [MW-1:0] ram_wem,
    input  logic [DW-1:0] ram_dout
);
    localparam int OFF = $clog2(MW);
    localparam int IW  = $clog2(DP);

    typedef enum logic {
        IDLE = 1'b0,
        RSP  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] last_raddr_q, last_raddr_d;
    logic          rsp_is_read_q, rsp_is_read_d;
    logic          rsp_err_q, rsp_err_d;

    logic          accept;
    logic          hit;
    logic [AW-1:0] word_idx;
    logic [AW-1:0] ram_idx;

    assign word_idx = cmd_addr >> OFF;

`ifdef SRAM_CTRL_ADDR_CHK_EN
    // Out-of-range commands are answered with an error and never reach the SRAM.
    assign hit     = (word_idx < AW'(DP));
    assign ram_idx = word_idx;
`else
    logic unused_idx_bits;
    // Without the check the index simply wraps onto the physical depth.
    assign hit             = 1'b1;
    assign ram_idx         = {{(AW-IW){1'b0}}, word_idx[IW-1:0]};
    assign unused_idx_bits = ^word_idx[AW-1:IW];
`endif

    // A new command can enter whenever the response slot is empty or being drained now.
    assign cmd_ready = (state_q == IDLE) | rsp_ready;
    assign accept    = cmd_valid & cmd_ready & rst_n;

    assign rsp_valid = (state_q == RSP);
    assign rsp_err   = rsp_err_q;
    // ram_dout holds the last read, so a stalled read response stays stable.
    assign rsp_rdata = rsp_is_read_q ? ram_dout : '0;

    // SRAM port: command drives it on accept, otherwise park on the last read index.
    always_comb begin
        ram_we   = 1'b0;
        ram_wem  = '0;
        ram_din  = '0;
        ram_addr = last_raddr_q;
        if (accept && hit) begin
            ram_addr = ram_idx;
            ram_we   = ~cmd_read;
            ram_wem  = cmd_wmask;
            ram_din  = cmd_wdata;
        end
    end

    // Next state: accept loads a fresh response; a drained response with no accept empties the slot.
    always_comb begin
        state_d       = state_q;
        last_raddr_d  = last_raddr_q;
        rsp_is_read_d = rsp_is_read_q;
        rsp_err_d     = rsp_err_q;
        if (accept) begin
            state_d       = RSP;
            rsp_is_read_d = cmd_read & hit;
            rsp_err_d     = ~hit;
            if (cmd_read && hit) begin
                last_raddr_d = ram_idx;
            end
        end else if (state_q == RSP && rsp_ready) begin
            state_d = IDLE;
        end
    end

    // State registers; reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_raddr_q  <= '0;
            rsp_is_read_q <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_raddr_q  <= last_raddr_d;
            rsp_is_read_q <= rsp_is_read_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter DP, default 512: SRAM depth in words.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter MW, default 4: byte-mask width, DW/8.
REQ-004 SHALL have parameter AW, default 32: byte-address width.
REQ-005 SHALL have ports:
- clk  in  1: single clock; all state on rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- cmd_valid  in  1: command present.
- cmd_ready  out  1: command accepted when cmd_valid&cmd_ready.
- cmd_read  in  1: 1 read, 0 write.
- cmd_addr  in  AW: byte address.
- cmd_wdata  in  DW: write data.
- cmd_wmask  in  MW: byte write enables.
- rsp_valid  out  1: response present.
- rsp_ready  in  1: response consumed when rsp_valid&rsp_ready.
- rsp_rdata  out  DW: read data.
- rsp_err  out  1: access error.
- ram_din  out  DW: SRAM write data.
- ram_addr  out  AW: SRAM word index.
- ram_we  out  1: SRAM write enable; 0 means read.
- ram_wem  out  MW: SRAM byte mask.
- ram_dout  in  DW: SRAM read data, valid one cycle after read address is presented, held until next read.

Function
REQ-006 SHALL implement two states: IDLE (no response pending) and RSP (response pending).
REQ-007 SHALL drive cmd_ready = (state==IDLE) | rsp_ready.
REQ-008 On accept, SHALL drive the SRAM in the same cycle: ram_addr = cmd_addr >> log2(MW), zero-extended; ram_we = ~cmd_read; ram_wem = cmd_wmask; ram_din = cmd_wdata.
REQ-009 In a cycle without accept, SHALL drive ram_we=0, ram_wem=0, ram_din=0, and ram_addr = registered last read word index (last_raddr), so SRAM output stays stable.
REQ-010 SHALL update last_raddr only on an accepted read.
REQ-011 The cycle after accept, SHALL enter RSP and assert rsp_valid; fixed latency 1 cycle.
REQ-012 rsp_rdata SHALL equal ram_dout for read responses and 0 for write responses, using a registered rsp_is_read flag.
REQ-013 SHALL hold rsp_valid, rsp_rdata, rsp_err stable while rsp_valid&~rsp_ready.
REQ-014 On rsp_valid&rsp_ready with no new accept, SHALL return to IDLE.
REQ-015 On rsp_valid&rsp_ready with a simultaneous accept, SHALL stay in RSP with the new command's response next cycle, sustaining one transaction per cycle.
REQ-016 A write with cmd_wmask=0 SHALL still assert ram_we and produce a response; memory is unchanged.
REQ-017 A read following a write to the same address SHALL return the newly written bytes.

Reset
REQ-018 While rst_n=0, SHALL force state=IDLE, rsp_valid=0, rsp_err=0, rsp_is_read=0, last_raddr=0; ram_we=0, ram_wem=0.
REQ-019 Reset asserted while RSP is pending SHALL discard the pending response without a handshake.

Configuration
REQ-020 With macro SRAM_CTRL_ADDR_CHK_EN defined, an accepted command with word index >= DP SHALL NOT access the SRAM (ram_we=0, last_raddr unchanged) and SHALL respond with rsp_err=1, rsp_rdata=0.
REQ-021 Without SRAM_CTRL_ADDR_CHK_EN, SHALL use the word index modulo DP (low log2(DP) bits) and SHALL tie rsp_err to 0.

Verification
REQ-022 Write 0x12345678 to 0x8 with mask 0xF, then read 0x8 -> read rsp_rdata=0x12345678, rsp_err=0, response 1 cycle after each accept.
REQ-023 Write 0xAABBCCDD to 0x0 with mask 0x5 over 0x00000001 -> read 0x0 returns 0x00BB00DD.
REQ-024 Read 0x4, hold rsp_ready=0 for 5 cycles -> rsp_rdata constant, cmd_ready=0, ram_addr=1 throughout.
REQ-025 Back-to-back reads of 0x0, 0x4, 0x8, 0xC with rsp_ready=1 -> four consecutive rsp_valid cycles returning the stored words in order.
REQ-026 With SRAM_CTRL_ADDR_CHK_EN, read 0x800 (index 512) -> rsp_err=1, rsp_rdata=0, no SRAM access; without the macro -> returns word 0.
REQ-027 Assert rst_n=0 while a response is stalled -> rsp_valid=0 immediately, cmd_ready=1 after release.
